// File: rtl/win_detector.sv
// Scans a snapshot of the 4x4 board one winning line per clock and reports P1/P2 win, draw or none.
// Optional WIN_MASK_EN adds the win_mask port reporting the cells of the deciding line.
module win_detector #(
    parameter int unsigned SIZE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SIZE*SIZE-1:0]   gameboard,
    input  logic [SIZE*SIZE-1:0]   players_cells,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             result
`ifdef WIN_MASK_EN
    ,
    output logic [SIZE*SIZE-1:0]   win_mask
`endif
);

    localparam int unsigned CELLS = SIZE * SIZE;
    localparam int unsigned LINES = 2 * SIZE + 2;
    localparam int unsigned IdxW  = $clog2(LINES);

    localparam logic [1:0] ResNone = 2'b00;
    localparam logic [1:0] ResP1   = 2'b01;
    localparam logic [1:0] ResP2   = 2'b10;
    localparam logic [1:0] ResDraw = 2'b11;

    typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CELLS-1:0]  board_q, owner_q;
    logic [1:0]        result_q, result_d;
    logic [CELLS-1:0]  line;
    logic              occupied, all_p1, all_p2, line_win, snap_en;
`ifdef WIN_MASK_EN
    logic [CELLS-1:0]  mask_q, mask_d;
`endif

    // Rows first, then columns, then main and anti diagonal.
    function automatic logic [CELLS-1:0] line_mask(input logic [IdxW-1:0] idx);
        logic [CELLS-1:0] m;
        logic [CELLS-1:0] one;
        int unsigned      k;
        int unsigned      pos;
        m   = '0;
        one = CELLS'(1);
        k   = 32'(idx);
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (k < SIZE) begin
                pos = k * SIZE + i;
            end else if (k < 2 * SIZE) begin
                pos = (k - SIZE) + i * SIZE;
            end else if (k == 2 * SIZE) begin
                pos = i * (SIZE + 1);
            end else begin
                pos = (i + 1) * (SIZE - 1);
            end
            m = m | (one << pos);
        end
        return m;
    endfunction

    always_comb begin
        line     = line_mask(idx_q);
        occupied = (board_q & line) == line;
        all_p1   = (owner_q & line) == '0;
        all_p2   = (owner_q & line) == line;
        line_win = occupied && (all_p1 || all_p2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            board_q  <= '0;
            owner_q  <= '0;
            result_q <= ResNone;
`ifdef WIN_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
`ifdef WIN_MASK_EN
            mask_q   <= mask_d;
`endif
            if (snap_en) begin
                board_q <= gameboard;
                owner_q <= players_cells;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        snap_en  = 1'b0;
`ifdef WIN_MASK_EN
        mask_d   = mask_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_en = 1'b1;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (line_win) begin
                    result_d = all_p1 ? ResP1 : ResP2;
`ifdef WIN_MASK_EN
                    mask_d   = line;
`endif
                    state_d  = StReport;
                end else if (idx_q == IdxW'(LINES - 1)) begin
                    result_d = (&board_q) ? ResDraw : ResNone;
`ifdef WIN_MASK_EN
                    mask_d   = '0;
`endif
                    state_d  = StReport;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == StScan);
        done     = (state_q == StReport);
        result   = result_q;
`ifdef WIN_MASK_EN
        win_mask = mask_q;
`endif
    end

endmodule
